conv_mac_serial: RTL and testbench

- Consumer of the conv1 weight ROM.
- Fetches the packed 5x5 filter and bias once through the ROM's read-enable and one-cycle registered output, then holds them locally.
- Accepts one 25-pixel window per handshake and computes bias plus the sum of pixel×weight serially, one tap per cycle.
- Emits a shifted, saturated result through a valid/ready handshake to the feature-map writer.

---
 rtl/conv_pkg.sv | 26 ++
 rtl/conv_out_quant.sv | 42 ++++
 rtl/conv_mac_serial.sv | 148 ++++++++++++++
 tb/tb_conv_mac_serial.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the conv layer MAC engines: tap count, FSM states,
// accumulator sizing and the packed weight ROM word layout.
package conv_pkg;

    localparam int TAPS_DEF = 25;
    localparam int BW_DEF   = 8;

    typedef enum logic [2:0] {
        W_REQ,
        W_CAP,
        IDLE,
        MAC,
        OUT
    } state_e;

    // Room for a full-scale BW x BW product summed over every tap plus the bias.
    function automatic int acc_w(input int bw, input int taps);
        return 2 * bw + $clog2(taps) + 1;
    endfunction

    // The bias entry sits directly after the last tap in the ROM word.
    function automatic int bias_idx(input int taps);
        return taps;
    endfunction

endpackage

// File: rtl/conv_out_quant.sv
// Output quantiser: arithmetic right shift, signed saturation to OUT_BW and,
// when CONV_RELU_EN is defined, clamping of negative results to zero.
module conv_out_quant #(
    parameter int ACC_W  = 22,
    parameter int SHIFT  = 0,
    parameter int OUT_BW = 16
) (
    input  logic [ACC_W-1:0]  acc_i,
    output logic [OUT_BW-1:0] data_o
);

    // One extra bit over the wider operand keeps the clamp limits representable.
    localparam int EW = ((ACC_W > OUT_BW) ? ACC_W : OUT_BW) + 1;
    localparam logic signed [EW-1:0] MAX_V = (EW'(1) << (OUT_BW - 1)) - EW'(1);
    localparam logic signed [EW-1:0] MIN_V = -(EW'(1) << (OUT_BW - 1));

    logic signed [ACC_W-1:0] shifted;
    logic signed [EW-1:0]    ext;
    logic signed [EW-1:0]    sat_v;

    function automatic logic signed [EW-1:0] sat(input logic signed [EW-1:0] v);
        if (v > MAX_V) begin
            return MAX_V;
        end else if (v < MIN_V) begin
            return MIN_V;
        end
        return v;
    endfunction

    always_comb begin
        shifted = $signed(acc_i) >>> SHIFT;
        ext     = {{(EW - ACC_W){shifted[ACC_W-1]}}, shifted};
        sat_v   = sat(ext);
        data_o  = sat_v[OUT_BW-1:0];
`ifdef CONV_RELU_EN
        if (sat_v[OUT_BW-1]) begin
            data_o = '0;
        end
`endif
    end

endmodule

// File: rtl/conv_mac_serial.sv
// Serial 5x5 conv MAC: fetches weights+bias from the conv1 ROM, then computes
// one tap per cycle per window. Optional ReLU via `define CONV_RELU_EN.
module conv_mac_serial
    import conv_pkg::*;
#(
    parameter int BW     = BW_DEF,
    parameter int TAPS   = TAPS_DEF,
    parameter int OUT_BW = 16,
    parameter int SHIFT  = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     o_read_en,
    input  logic [BW*(TAPS+1)-1:0]   i_weight_data,
    input  logic                     i_reload,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [BW*TAPS-1:0]       i_window,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [OUT_BW-1:0]        o_data
);

    localparam int ACC_W = acc_w(BW, TAPS);
    localparam int TAP_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int BIDX  = bias_idx(TAPS);

    state_e                  state_q, state_d;
    logic signed [BW-1:0]    wgt_q [TAPS];
    logic signed [BW-1:0]    bias_q;
    logic signed [BW-1:0]    pix_q [TAPS];
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [TAP_W-1:0]        tap_q, tap_d;
    logic                    valid_q, valid_d;
    logic [OUT_BW-1:0]       data_q, data_d;
    logic                    wcap;
    logic                    accept;

    logic signed [2*BW-1:0]  prod;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [ACC_W-1:0] bias_ext;
    logic [OUT_BW-1:0]       quant;

    always_comb begin
        prod     = pix_q[tap_q] * wgt_q[tap_q];
        acc_sum  = acc_q + {{(ACC_W - 2*BW){prod[2*BW-1]}}, prod};
        bias_ext = {{(ACC_W - BW){bias_q[BW-1]}}, bias_q};
    end

    conv_out_quant #(
        .ACC_W  (ACC_W),
        .SHIFT  (SHIFT),
        .OUT_BW (OUT_BW)
    ) u_quant (
        .acc_i  (acc_sum),
        .data_o (quant)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        tap_d   = tap_q;
        valid_d = valid_q;
        data_d  = data_q;
        wcap    = 1'b0;
        accept  = 1'b0;
        case (state_q)
            W_REQ: state_d = W_CAP;
            W_CAP: begin
                wcap    = 1'b1;
                state_d = IDLE;
            end
            IDLE: begin
                // A reload request wins; the window stays offered for later.
                if (i_reload) begin
                    state_d = W_REQ;
                end else if (i_valid) begin
                    accept  = 1'b1;
                    acc_d   = bias_ext;
                    tap_d   = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = acc_sum;
                tap_d = tap_q + TAP_W'(1);
                if (tap_q == TAP_W'(TAPS - 1)) begin
                    data_d  = quant;
                    valid_d = 1'b1;
                    tap_d   = '0;
                    state_d = OUT;
                end
            end
            OUT: begin
                if (i_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = W_REQ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= W_REQ;
            acc_q   <= '0;
            tap_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            tap_q   <= tap_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) begin
                wgt_q[i] <= '0;
            end
            bias_q <= '0;
        end else if (wcap) begin
            for (int i = 0; i < TAPS; i++) begin
                wgt_q[i] <= i_weight_data[i*BW +: BW];
            end
            bias_q <= i_weight_data[BIDX*BW +: BW];
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < TAPS; i++) begin
                pix_q[i] <= i_window[i*BW +: BW];
            end
        end
    end

    // The state register resets to W_REQ, so the strobe is masked while reset is held.
    assign o_read_en = (state_q == W_REQ) && !rst;
    assign o_ready   = (state_q == IDLE);
    assign o_valid   = valid_q;
    assign o_data    = data_q;

endmodule

// File: tb/tb_conv_mac_serial.sv
// Directed bench for conv_mac_serial: a default instance (OUT_BW=16, SHIFT=0)
// and a narrow one (OUT_BW=8, SHIFT=2) share one ROM model and one stimulus.
module tb_conv_mac_serial;

    localparam int BW   = 8;
    localparam int TAPS = 25;
`ifdef CONV_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic                    clk;
    logic                    rst;
    logic                    i_reload;
    logic                    i_valid;
    logic                    i_ready;
    logic [BW*TAPS-1:0]      i_window;
    logic [BW*(TAPS+1)-1:0]  rom_word;
    logic [BW*(TAPS+1)-1:0]  rom_q;
    logic                    rd0, rd1, rdy0, rdy1, v0, v1;
    logic signed [15:0]      d0;
    logic signed [7:0]       d1;

    int checks = 0;
    int errors = 0;

    conv_mac_serial #(.BW(BW), .TAPS(TAPS), .OUT_BW(16), .SHIFT(0)) dut0 (
        .clk(clk), .rst(rst), .o_read_en(rd0), .i_weight_data(rom_q),
        .i_reload(i_reload), .i_valid(i_valid), .o_ready(rdy0),
        .i_window(i_window), .o_valid(v0), .i_ready(i_ready), .o_data(d0)
    );

    conv_mac_serial #(.BW(BW), .TAPS(TAPS), .OUT_BW(8), .SHIFT(2)) dut1 (
        .clk(clk), .rst(rst), .o_read_en(rd1), .i_weight_data(rom_q),
        .i_reload(i_reload), .i_valid(i_valid), .o_ready(rdy1),
        .i_window(i_window), .o_valid(v1), .i_ready(i_ready), .o_data(d1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM with one-cycle registered output.
    always @(posedge clk) begin
        if (rd0) rom_q <= rom_word;
    end

    task automatic check(input string tag, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int relu(input int x);
        return (RELU && x < 0) ? 0 : x;
    endfunction

    function automatic logic [BW*(TAPS+1)-1:0] mk_word(input int w, input int b);
        logic [BW*(TAPS+1)-1:0] r;
        r = '0;
        for (int i = 0; i < TAPS; i++) r[i*BW +: BW] = w[BW-1:0];
        r[TAPS*BW +: BW] = b[BW-1:0];
        return r;
    endfunction

    function automatic logic [BW*TAPS-1:0] mk_win(input int p);
        logic [BW*TAPS-1:0] r;
        for (int i = 0; i < TAPS; i++) r[i*BW +: BW] = p[BW-1:0];
        return r;
    endfunction

    task automatic load(input int w, input int b);
        int n;
        rom_word = mk_word(w, b);
        i_reload = 1'b1;
        @(negedge clk);
        i_reload = 1'b0;
        check("reload_strobe", rd0, 1);
        n = 0;
        while (!rdy0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("reload_ready", rdy0, 1);
    endtask

    task automatic accept(input int p);
        i_window = mk_win(p);
        i_valid  = 1'b1;
        check("accept_ready", rdy0, 1);
        @(negedge clk);
        i_valid  = 1'b0;
    endtask

    task automatic wait_result(input string tag, input int exp0, input int exp1);
        int n;
        n = 0;
        while (!v0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, n, TAPS);
        check({tag, "_valid1"}, v1, 1);
        check({tag, "_d16"}, d0, exp0);
        check({tag, "_d8"}, d1, exp1);
    endtask

    task automatic finish_out();
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        check("hs_valid_low", v0, 0);
        check("hs_ready_high", rdy0, 1);
    endtask

    initial begin
        int  n;
        bit  stable;
        bit  seen;
        rst      = 1'b1;
        i_reload = 1'b0;
        i_valid  = 1'b0;
        i_ready  = 1'b0;
        i_window = '0;
        rom_word = mk_word(1, 0);
        rom_q    = '0;
        repeat (3) @(negedge clk);

        check("rst_read_en", rd0, 0);
        check("rst_ready", rdy0, 0);
        check("rst_valid", v0, 0);
        check("rst_data", d0, 0);
        rst = 1'b0;
        #1 check("boot_strobe", rd0, 1);
        @(negedge clk);
        check("boot_strobe_off", rd0, 0);
        check("boot_ready_wcap", rdy0, 0);
        @(negedge clk);
        check("boot_ready", rdy0, 1);

        // weights 1, bias 0, pixels 2: 50, and 50>>>2 = 12 on the narrow instance
        accept(2);
        wait_result("basic", 50, 12);
        finish_out();

        load(127, 0);
        accept(127);
        wait_result("sat_pos", 32767, 127);
        finish_out();

        load(-128, 0);
        accept(127);
        wait_result("sat_neg", relu(-32768), relu(-128));
        finish_out();

        load(0, -5);
        accept(7);
        wait_result("bias_only", relu(-5), relu(-2));
        finish_out();

        load(1, 0);
        accept(4);
        wait_result("shift", 100, 25);
        finish_out();

        // Backpressure with a second window offered during the hold
        accept(3);
        wait_result("bp_first", 75, 18);
        i_window = mk_win(-1);
        i_valid  = 1'b1;
        stable   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (d0 !== 16'sd75 || v0 !== 1'b1 || rdy0 !== 1'b0 || d1 !== 8'sd18) stable = 1'b0;
        end
        check("bp_hold_stable", stable, 1);
        finish_out();
        @(negedge clk);
        i_valid = 1'b0;
        wait_result("bp_second", relu(-25), relu(-7));
        finish_out();

        // Reset in the middle of a MAC run at tap 12
        accept(2);
        repeat (11) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_read_en", rd0, 0);
        check("midrst_ready", rdy0, 0);
        check("midrst_valid", v0, 0);
        check("midrst_d16", d0, 0);
        check("midrst_d8", d1, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 check("midrst_refetch", rd0, 1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (v0 || v1) seen = 1'b1;
        end
        check("midrst_no_stale", seen, 0);
        accept(1);
        wait_result("post_rst", 25, 6);
        finish_out();

        // Reload together with a valid window: reload wins
        rom_word = mk_word(2, 0);
        i_window = mk_win(1);
        i_valid  = 1'b1;
        i_reload = 1'b1;
        @(negedge clk);
        i_reload = 1'b0;
        check("rl_strobe", rd0, 1);
        check("rl_not_accepted", rdy0, 0);
        @(negedge clk);
        check("rl_wcap_ready", rdy0, 0);
        @(negedge clk);
        check("rl_idle_ready", rdy0, 1);
        @(negedge clk);
        i_valid = 1'b0;
        wait_result("rl_result", 50, 12);
        finish_out();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
